// File: rtl/sample_proj_pkg.sv
// Shared types and constants for the sample_proj control stage.
// Imported by the monitor and the sequencing FSM.
package sample_proj_pkg;

   localparam int NUM_PINS = 34;
   localparam int PRESC_W  = 14;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      FLT_NONE   = 2'd0,
      FLT_CFG    = 2'd1,
      FLT_WDOG   = 2'd2,
      FLT_ONEHOT = 2'd3
   } fault_t;

   // True when more than one bit of v is set.
   function automatic logic is_multi_hot(input logic [NUM_PINS-1:0] v);
      return (v & (v - NUM_PINS'(1))) != '0;
   endfunction

endpackage

// File: rtl/sample_proj_seq_ctrl_monitor.sv
// Watches sample_proj's done and out lines: lap edges, stalls
// and one-hot violations, qualified by the RUN state.
module sample_proj_monitor
   import sample_proj_pkg::*;
#(
   parameter int WD_W = 29
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                active,
   input  logic                done_in,
   input  logic [NUM_PINS-1:0] out_in,
   input  logic [WD_W-1:0]     wd_limit,
   output logic                lap_pulse,
   output logic                wdog_expired,
   output logic                onehot_err
);

   logic                done_q;
   logic [NUM_PINS-1:0] out_q;
   logic [WD_W-1:0]     wd_cnt;
   logic [WD_W-1:0]     wd_nxt;
   logic                changed;

   always_comb begin
      changed = (out_in != out_q);
      if (changed)
         wd_nxt = '0;
      else if (&wd_cnt)
         wd_nxt = wd_cnt;
      else
         wd_nxt = wd_cnt + WD_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b0;
         out_q  <= '0;
         wd_cnt <= '0;
      end else begin
         done_q <= done_in;
         out_q  <= out_in;
         wd_cnt <= active ? wd_nxt : '0;
      end
   end

   // Expiry looks at the next count so the fault lands on the
   // same edge the counter would reach the limit.
   assign lap_pulse    = active & done_in & ~done_q;
   assign wdog_expired = active && (wd_nxt >= wd_limit);
   assign onehot_err   = active && is_multi_hot(out_in);

endmodule

// File: rtl/sample_proj_seq_ctrl.sv
// Control stage for sample_proj: runs the one-hot sweep for a
// programmed number of laps, then stops and reports status.
module sample_proj_seq_ctrl
   import sample_proj_pkg::*;
#(
   parameter int CYCLES_PER_MS = 10000,
   parameter int STOP_HOLD     = 5,
   parameter int LAP_W         = 8,
   parameter int WD_W          = 29
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [PRESC_W-1:0]  period_ms,
   input  logic [LAP_W-1:0]    lap_target,
   input  logic                done_in,
   input  logic [NUM_PINS-1:0] out_in,
   output logic                enable,
   output logic                stop,
   output logic [PRESC_W-1:0]  prescaler,
   output logic                busy,
   output logic                finished,
   output logic [LAP_W-1:0]    laps_done,
   output logic [1:0]          fault
);

   localparam int HOLD_W = $clog2(STOP_HOLD + 1);

   state_t            state;
   fault_t            fault_q;
   logic [WD_W-1:0]   wd_limit;
   logic [LAP_W-1:0]  lap_tgt_q;
   logic [LAP_W-1:0]  laps_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              lap_pulse;
   logic              wdog_expired;
   logic              onehot_err;
   logic              last_lap;
   logic              cfg_bad;
   logic              run_end;

   sample_proj_monitor #(
      .WD_W (WD_W)
   ) u_mon (
      .clk          (clk),
      .rst          (rst),
      .active       (state == RUN),
      .done_in      (done_in),
      .out_in       (out_in),
      .wd_limit     (wd_limit),
      .lap_pulse    (lap_pulse),
      .wdog_expired (wdog_expired),
      .onehot_err   (onehot_err)
   );

   assign laps_nxt = laps_done + LAP_W'(1);
   assign last_lap = lap_pulse && (laps_nxt == lap_tgt_q);
   assign cfg_bad  = (period_ms == '0) || (lap_target == '0);
   assign run_end  = onehot_err | wdog_expired | abort | last_lap;
   assign fault    = fault_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         enable    <= 1'b0;
         stop      <= 1'b0;
         prescaler <= '0;
         busy      <= 1'b0;
         finished  <= 1'b0;
         laps_done <= '0;
         fault_q   <= FLT_NONE;
         wd_limit  <= '0;
         lap_tgt_q <= '0;
         hold_cnt  <= '0;
      end else begin
         finished <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && cfg_bad) begin
                  fault_q <= FLT_CFG;
               end else if (start) begin
                  prescaler <= period_ms;
                  wd_limit  <= WD_W'(2 * CYCLES_PER_MS)
                             * WD_W'(period_ms);
                  lap_tgt_q <= lap_target;
                  laps_done <= '0;
                  fault_q   <= FLT_NONE;
                  enable    <= 1'b1;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (lap_pulse)
                  laps_done <= laps_nxt;
               if (onehot_err)
                  fault_q <= FLT_ONEHOT;
               else if (wdog_expired)
                  fault_q <= FLT_WDOG;
               if (run_end) begin
                  stop     <= 1'b1;
                  hold_cnt <= '0;
                  state    <= STOP;
               end
            end
            STOP: begin
               if (hold_cnt == HOLD_W'(STOP_HOLD - 1)) begin
                  stop     <= 1'b0;
                  enable   <= 1'b0;
                  busy     <= 1'b0;
                  finished <= 1'b1;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
